// File: rtl/button_pulse_gen.sv
// -----------------------------------------------------------------------------
// button_pulse_gen
//
// Debounces one raw push-button. Each accepted press produces a single-cycle
// press_pulse, and each accepted release produces a single-cycle release_pulse.
// The press pulse drives the count enable of a downstream BCD counter, which
// has no way to stall this block.
//
// Optional feature (macro BTN_AUTOREPEAT_EN): while the button stays held,
// further press pulses are produced. The first comes REPEAT_DELAY cycles after
// the accepted press, and later ones come every REPEAT_PERIOD cycles. When the
// macro is undefined, the repeat counter does not exist and each press gives
// exactly one pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press or release (>= 1)
//   REPEAT_DELAY     cycles from press_pulse to the first repeat pulse (>= 1)
//   REPEAT_PERIOD    cycles between later repeat pulses (>= 1)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   btn            raw button, asynchronous to clk, active-high, bouncy
//   press_pulse    one-cycle pulse per accepted press (and per repeat)
//   release_pulse  one-cycle pulse per accepted release
//   btn_level      debounced button level
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_pulse,
    output logic release_pulse,
    output logic btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Stop elaboration on an illegal parameter set. This check also uses the
    // repeat parameters when the repeat logic is compiled out.
    generate
        if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
            $error("button_pulse_gen: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t          state_q;
    logic            s1_q;
    logic            s2_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            press_q;
    logic            release_q;
    logic            level_q;

    assign cnt_d = cnt_q + CW'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RDELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]   rcnt_q;
    logic [RW-1:0]   rcnt_d;
    logic            first_q;   // still waiting for the first (delay) repeat
    logic            rep_hit;

    assign rcnt_d  = rcnt_q + RW'(1);
    assign rep_hit = first_q ? (rcnt_q == RDELAY_LAST) : (rcnt_q == RPERIOD_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_q    <= '0;
            first_q   <= 1'b1;
`endif
        end else begin
            s1_q      <= btn;
            s2_q      <= s1_q;
            // Pulses last one cycle unless set again below.
            press_q   <= 1'b0;
            release_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (s2_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (!s2_q) begin
                        state_q <= IDLE;            // bounce: no pulse
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                        press_q <= 1'b1;
                        level_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rcnt_q  <= '0;
                        first_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                HELD: begin
                    if (!s2_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (rep_hit) begin
                        press_q <= 1'b1;
                        rcnt_q  <= '0;
                        first_q <= 1'b0;
                    end else begin
                        rcnt_q <= rcnt_d;
                    end
`endif
                end

                RELEASE_WAIT: begin
                    if (s2_q) begin
                        // Release bounce: level stays high and the repeat wait
                        // restarts from the full delay.
                        state_q <= HELD;
`ifdef BTN_AUTOREPEAT_EN
                        rcnt_q  <= '0;
                        first_q <= 1'b1;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign btn_level     = level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// -----------------------------------------------------------------------------
// Testbench for button_pulse_gen (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=3).
//
// The reference model does not track the FSM. It tracks the debounced level.
// The level toggles once s2 has differed from it for DEBOUNCE_CYCLES+1
// consecutive edges.
//
// While the level is high and the button stays high, the model counts edges
// since the press, or since the last return from a release bounce. It emits
// repeat presses at the delay boundary and then at each period boundary.
//
// Expected pulses are queued with their edge number. A monitor on the falling
// edge pops the queue when a pulse appears.
// -----------------------------------------------------------------------------
module tb_button_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic press_pulse;
    logic release_pulse;
    logic btn_level;

    button_pulse_gen #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .btn_level     (btn_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit kind;   // 1 = press, 0 = release
        int cyc;    // edge count after which the pulse is visible
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    bit m_s1 = 0, m_s2 = 0, m_lvl = 0, m_first = 1;
    int m_run = 0, m_h = 0;

    function automatic void push_exp(bit kind);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc + 1;
        q.push_back(e);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit x;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_h = 0; m_first = 1;
            q.delete();
        end else begin
            x = m_s2;               // synchronized value seen at this edge
            m_s2 = m_s1;
            m_s1 = btn;
            if (x == m_lvl) begin
`ifdef BTN_AUTOREPEAT_EN
                if (m_lvl && m_run > 0) begin
                    m_h = 0; m_first = 1;     // came back from a release bounce
                end else if (m_lvl) begin
                    m_h++;
                    if (m_h == (m_first ? RD : RP)) begin
                        push_exp(1'b1);
                        m_h = 0; m_first = 0;
                    end
                end
`endif
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == D + 1) begin
                    m_lvl = x;
                    m_run = 0;
                    m_h = 0; m_first = 1;
                    push_exp(x);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            n_checks++;
            if (btn_level !== m_lvl) begin
                n_fail++;
                $display("FAIL btn_level cyc=%0d got=%b exp=%b", cyc, btn_level, m_lvl);
            end
            if (press_pulse === 1'b1 || release_pulse === 1'b1) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b exp=none",
                             cyc, press_pulse, release_pulse);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || press_pulse !== e.kind || release_pulse !== !e.kind) begin
                        n_fail++;
                        $display("FAIL pulse cyc=%0d press=%b release=%b exp_cyc=%0d exp_kind=%s",
                                 cyc, press_pulse, release_pulse, e.cyc, e.kind ? "press" : "release");
                    end else begin
                        $display("pulse %s at cyc=%0d ok", e.kind ? "press" : "release", cyc);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                n_checks++;
                n_fail++;
                e = q.pop_front();
                $display("FAIL missing_pulse cyc=%0d got=none exp_kind=%s exp_cyc=%0d",
                         cyc, e.kind ? "press" : "release", e.cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_zero(input string name);
        n_checks++;
        if (press_pulse !== 1'b0 || release_pulse !== 1'b0 || btn_level !== 1'b0) begin
            n_fail++;
            $display("FAIL %s press=%b release=%b level=%b exp=0/0/0",
                     name, press_pulse, release_pulse, btn_level);
        end
    endtask

    // Called at posedge+2; asserts reset between edges and checks that it acts at once.
    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        repeat (n) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic hold(input bit v, input int n);
        btn = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_values");
        rst = 1'b0;
        hold(0, 5);

        // clean press and release
        hold(1, 14);
        hold(0, 14);
        // press bounce, then steady
        hold(1, 3); hold(0, 2); hold(1, 14);
        // release bounce, then steady
        hold(0, 2); hold(1, 1); hold(0, 14);
        // reset in the middle of press debounce, button kept high
        hold(1, 4);
        do_reset(2);
        hold(1, 16);
        hold(0, 14);
        // long hold for repeat behaviour
        hold(1, 30);
        hold(0, 2); hold(1, 1);       // release bounce restarts repeat delay
        hold(1, 20);
        hold(0, 14);
        // reset while a pulse is in flight: press accepted exactly at this edge
        hold(1, 2 + D + 1);
        do_reset(1);
        hold(0, 10);

        // randomized segments
        for (int i = 0; i < 300; i++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 25))
                                              : int'($urandom_range(1, 4));
            hold(1'($urandom_range(0, 1)), len);
            if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 3)));
        end

        hold(0, 30);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_pulse_gen.md
# button_pulse_gen

Debounces one raw push-button and converts each accepted press into a single-cycle `press_pulse`. This pulse drives the count-enable input of the 3-digit BCD counter stage. The block sits between the board button pin and the counter, in the same `clk` domain as the display logic. An optional auto-repeat generates further pulses while the button is held.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a press or release (10 ms at 50 MHz); legal range ≥ 1.
- `REPEAT_DELAY`, 25000000: cycles from `press_pulse` to the first auto-repeat pulse; must be ≥ 1.
- `REPEAT_PERIOD`, 5000000: cycles between later auto-repeat pulses; must be ≥ 1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn`  in  1  raw button, asynchronous to `clk`, active-high, bouncy.
- `press_pulse`  out  1  one-cycle pulse per accepted press (and per auto-repeat).
- `release_pulse`  out  1  one-cycle pulse per accepted release.
- `btn_level`  out  1  debounced button level.

## Operation
- **Synchronizer:** two flops, `btn` → `s1` → `s2`, both reset to 0. All decisions below use `s2` only.
- **Debounce counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`. A separate repeat counter `rcnt` is sized for `max(REPEAT_DELAY, REPEAT_PERIOD)`.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Reset state is IDLE.
- **IDLE:**
  - `s2`=1 → PRESS_WAIT, `cnt`←0.
  - `s2`=0 → stay in IDLE.
- **PRESS_WAIT:**
  - `s2`=0 → IDLE. This is a rejected bounce: no pulse is produced.
  - `s2`=1 and `cnt`==DEBOUNCE_CYCLES-1 → HELD. Assert `press_pulse` for one cycle, set `btn_level`←1, set `rcnt`←0.
  - Otherwise `cnt`++.
- **HELD:**
  - `s2`=0 → RELEASE_WAIT, `cnt`←0.
  - Otherwise, auto-repeat runs if compiled in (see Configuration).
- **RELEASE_WAIT:**
  - `s2`=1 → HELD. This is a release bounce: no pulse, `btn_level` stays 1, `rcnt`←0.
  - `s2`=0 and `cnt`==DEBOUNCE_CYCLES-1 → IDLE. Assert `release_pulse` for one cycle, set `btn_level`←0.
  - Otherwise `cnt`++.
- **Registered outputs:** all outputs come directly from flops; there is no combinational path from `btn`.
- **Pulse exclusivity:** `press_pulse` and `release_pulse` are never high in the same cycle.
- **Counter wrap:** counters never wrap. `cnt` is bounded by DEBOUNCE_CYCLES-1 and `rcnt` by its terminal value.

## Timing
- **Reset values:** `press_pulse`=0, `release_pulse`=0, `btn_level`=0. FSM=IDLE, `cnt`=0, `rcnt`=0, `s1`=`s2`=0.
- **Reset mid-operation:** asserting `rst` at any time forces the reset values immediately, without waiting for a clock.
  - A pulse in flight is cut short.
  - After `rst` deasserts, a button still held must be re-debounced from IDLE.
- **Press latency:** let edge k be the first edge at which `s1` samples `btn`=1.
  - `s2`=1 after edge k+1; PRESS_WAIT is entered at edge k+2.
  - `press_pulse` and `btn_level` rise at edge k+2+DEBOUNCE_CYCLES. `press_pulse` falls at the next edge.
- **Release latency:** symmetric. `release_pulse` rises, and `btn_level` falls, at edge j+2+DEBOUNCE_CYCLES, where edge j is the first edge that samples `btn`=0.
- **Glitch rejection:** a glitch of `btn` shorter than DEBOUNCE_CYCLES cycles, as seen at `s2`, produces no pulse and no change in `btn_level`.
- **Downstream handshake:** the consuming counter must act on every cycle in which `press_pulse`=1; there is no backpressure.

## Configuration
- Macro: `BTN_AUTOREPEAT_EN`.
- **Defined:** while in HELD, `rcnt` increments every cycle.
  - The first repeat pulse comes REPEAT_DELAY cycles after the accepted `press_pulse`: `rcnt`==REPEAT_DELAY-1 → pulse and `rcnt`←0.
  - Later pulses come every REPEAT_PERIOD cycles: `rcnt`==REPEAT_PERIOD-1 → pulse and `rcnt`←0.
  - A repeat pulse is one cycle on `press_pulse`.
  - Leaving HELD cancels repeat. A return from RELEASE_WAIT restarts the REPEAT_DELAY wait.
- **Undefined:** `rcnt` and the repeat logic are absent; exactly one `press_pulse` is produced per accepted press.

## Test plan
- **Clean press:** DEBOUNCE_CYCLES=4, `btn` 0→1 sampled at edge 10 and held → `press_pulse`=1 only in the cycle after edge 16; `btn_level`=1 from edge 16.
- **Bounce rejection:** `btn` high 3 cycles, low 2, then high steady (DEBOUNCE_CYCLES=4) → exactly one `press_pulse`, counted from the last rising transition.
- **Release and release bounce:** from HELD, `btn` low 2 cycles, high 1, then low steady → no pulse during the bounce; one `release_pulse` at steady-low +6 edges; `btn_level`=0 from then.
- **Reset mid-debounce:** `rst` asserted asynchronously between clock edges during PRESS_WAIT with `btn` held → outputs 0 immediately; after release of `rst`, `press_pulse` occurs 6 edges after the first edge at which `s1` samples `btn`=1 again.
- **Auto-repeat:** `BTN_AUTOREPEAT_EN` defined, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, `btn` held 20 cycles past the accept edge → `press_pulse` at accept+0, +8, +11, +14, +17, +20.
- **Auto-repeat compiled out:** same stimulus with `BTN_AUTOREPEAT_EN` undefined → a single `press_pulse`.
